// File: rtl/token_scheduler_fsm_pkg.sv
// Shared token-engine definitions: layer-type encodings, scheduler states,
// default lane count and counter widths.
package token_scheduler_fsm_pkg;

    localparam int NUM_COL_DEFAULT = 32;
    localparam int PREHEAT_CNT_W   = 6;
    localparam int TILE_CNT_W      = 16;

    typedef enum logic [1:0] {
        LT_POINTWISE = 2'd0,
        LT_DEPTHWISE = 2'd1,
        LT_STANDARD  = 2'd2,
        LT_LINEAR    = 2'd3
    } layer_type_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PREHEAT     = 3'd1,
        ST_NORMAL_LOOP = 3'd2,
        ST_DRAIN       = 3'd3,
        ST_DONE        = 3'd4
    } sched_state_e;

    // A first pass has no partial sums yet, and depthwise layers never
    // accumulate across input channels, so both skip the ipsum FIFOs.
    function automatic logic ipsum_exempt(input logic first_pass, input layer_type_e layer_type);
        return first_pass || (layer_type == LT_DEPTHWISE);
    endfunction

endpackage

// File: rtl/token_scheduler_fsm_if.sv
// Per-lane FIFO status flags and pop/push strobes between the scheduler
// (master) and the FIFO bank (slave).
interface token_scheduler_fsm_if
    import token_scheduler_fsm_pkg::*;
#(
    parameter int NUM_COL = NUM_COL_DEFAULT
);

    logic [NUM_COL-1:0] ifmap_fifo_empty_i;
    logic [NUM_COL-1:0] ipsum_fifo_empty_i;
    logic [NUM_COL-1:0] opsum_fifo_afull_i;
    logic [NUM_COL-1:0] ifmap_fifo_pop_matrix_o;
    logic [NUM_COL-1:0] ipsum_fifo_pop_matrix_o;
    logic [NUM_COL-1:0] opsum_fifo_push_matrix_o;

    modport master (
        input  ifmap_fifo_empty_i,
        input  ipsum_fifo_empty_i,
        input  opsum_fifo_afull_i,
        output ifmap_fifo_pop_matrix_o,
        output ipsum_fifo_pop_matrix_o,
        output opsum_fifo_push_matrix_o
    );

    modport slave (
        output ifmap_fifo_empty_i,
        output ipsum_fifo_empty_i,
        output opsum_fifo_afull_i,
        input  ifmap_fifo_pop_matrix_o,
        input  ipsum_fifo_pop_matrix_o,
        input  opsum_fifo_push_matrix_o
    );

endinterface

// File: rtl/token_scheduler_fsm_preheat_lane_counter.sv
// One lane of the preheat phase: counts ifmap pops up to the preheat depth
// and reports when the lane has nothing left to preload.
module preheat_lane_counter
    import token_scheduler_fsm_pkg::*;
#(
    parameter int PREHEAT_DEPTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic active_i,
    input  logic col_en_i,
    input  logic fifo_empty_i,
    output logic pop_o,
    output logic lane_done_o
);

    localparam logic [PREHEAT_CNT_W-1:0] DEPTH = PREHEAT_CNT_W'(PREHEAT_DEPTH);

    logic [PREHEAT_CNT_W-1:0] cnt_q, cnt_d;

    // Pop whenever the lane is enabled, has data and still owes preheat tokens.
    always_comb begin
        pop_o = active_i && col_en_i && !fifo_empty_i && (cnt_q < DEPTH);
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (pop_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Disabled lanes never hold up the exit from preheat.
    assign lane_done_o = !col_en_i || (cnt_q == DEPTH);

    // Pop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/token_scheduler_fsm.sv
// Token scheduler: preloads ifmap tokens into every active PE column, then
// issues lock-step beats across all active lanes, and reports completion.
module token_scheduler_fsm
    import token_scheduler_fsm_pkg::*;
#(
    parameter int NUM_COL       = NUM_COL_DEFAULT,
    parameter int PREHEAT_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [1:0]            layer_type_i,
    input  logic [TILE_CNT_W-1:0] cfg_num_tiles_i,
    input  logic [NUM_COL-1:0]    cfg_col_en_i,
    input  logic                  cfg_first_pass_i,
    token_scheduler_fsm_if.master fifo_if,
    output logic                  preheat_state_o,
    output logic                  normal_loop_state_o,
    output logic                  busy_o,
    output logic                  done_o
);

    sched_state_e          state_q, state_d;
    layer_type_e           layer_type_q, layer_type_d;
    logic [TILE_CNT_W-1:0] tiles_q, tiles_d;
    logic [TILE_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [NUM_COL-1:0]    col_en_q, col_en_d;
    logic                  first_pass_q, first_pass_d;
    logic [NUM_COL-1:0]    push_q, push_d;

    logic [NUM_COL-1:0]    lane_pop;
    logic [NUM_COL-1:0]    lane_done;
    logic [NUM_COL-1:0]    lane_ok;
    logic [NUM_COL-1:0]    beat_mask;
    logic                  clear_cnt;
    logic                  ipsum_skip;
    logic                  beat;

    for (genvar c = 0; c < NUM_COL; c++) begin : g_lane
        preheat_lane_counter #(
            .PREHEAT_DEPTH (PREHEAT_DEPTH)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear_i      (clear_cnt),
            .active_i     (state_q == ST_PREHEAT),
            .col_en_i     (col_en_q[c]),
            .fifo_empty_i (fifo_if.ifmap_fifo_empty_i[c]),
            .pop_o        (lane_pop[c]),
            .lane_done_o  (lane_done[c])
        );
    end

    // A beat needs every enabled lane ready at once so lanes never drift apart.
    always_comb begin
        ipsum_skip = ipsum_exempt(first_pass_q, layer_type_q);
        lane_ok    = ~col_en_q | (~fifo_if.ifmap_fifo_empty_i
                                  & ({NUM_COL{ipsum_skip}} | ~fifo_if.ipsum_fifo_empty_i)
                                  & ~fifo_if.opsum_fifo_afull_i);
        beat       = (state_q == ST_NORMAL_LOOP) && (&lane_ok);
        beat_mask  = beat ? col_en_q : '0;
        push_d     = beat_mask;
    end

    // Next-state logic, config capture at start and beat counting.
    always_comb begin
        state_d      = state_q;
        layer_type_d = layer_type_q;
        tiles_d      = tiles_q;
        col_en_d     = col_en_q;
        first_pass_d = first_pass_q;
        beat_cnt_d   = beat_cnt_q;
        clear_cnt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    layer_type_d = layer_type_e'(layer_type_i);
                    tiles_d      = cfg_num_tiles_i;
                    col_en_d     = cfg_col_en_i;
                    first_pass_d = cfg_first_pass_i;
                    beat_cnt_d   = '0;
                    clear_cnt    = 1'b1;
                    state_d      = ST_PREHEAT;
                end
            end
            ST_PREHEAT: begin
                if (&lane_done) begin
                    state_d = (tiles_q != '0) ? ST_NORMAL_LOOP : ST_DRAIN;
                end
            end
            ST_NORMAL_LOOP: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_d == tiles_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, latched configuration and registered opsum push mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            layer_type_q <= LT_POINTWISE;
            tiles_q      <= '0;
            col_en_q     <= '0;
            first_pass_q <= 1'b0;
            beat_cnt_q   <= '0;
            push_q       <= '0;
        end else begin
            state_q      <= state_d;
            layer_type_q <= layer_type_d;
            tiles_q      <= tiles_d;
            col_en_q     <= col_en_d;
            first_pass_q <= first_pass_d;
            beat_cnt_q   <= beat_cnt_d;
            push_q       <= push_d;
        end
    end

    // Phase flags decode only the registered state, so FIFO flags cannot glitch them.
    always_comb begin
        preheat_state_o                  = (state_q == ST_PREHEAT);
        normal_loop_state_o              = (state_q == ST_NORMAL_LOOP);
        busy_o                           = (state_q != ST_IDLE);
        done_o                           = (state_q == ST_DONE);
        fifo_if.ifmap_fifo_pop_matrix_o  = lane_pop | beat_mask;
        fifo_if.ipsum_fifo_pop_matrix_o  = ipsum_skip ? '0 : beat_mask;
        fifo_if.opsum_fifo_push_matrix_o = push_q;
    end

endmodule

// File: tb/tb_token_scheduler_fsm.sv
// Scoreboard bench for token_scheduler_fsm: each job queues its hand-derived
// strobe/done events, and a negedge monitor pops and compares them.
module tb_token_scheduler_fsm;
    import token_scheduler_fsm_pkg::*;

    localparam int NUM_COL = 32;
    localparam int MAX_CYC = 64;

    typedef struct {
        int          cyc;
        logic [31:0] ifPop;
        logic [31:0] ipPop;
        logic [31:0] opPush;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic [1:0] layerType = 2'd0;
    logic [15:0] numTiles = '0;
    logic [NUM_COL-1:0] colEn = '0;
    logic firstPass = 1'b0;
    logic [NUM_COL-1:0] ifmapEmpty = '1;
    logic [NUM_COL-1:0] ipsumEmpty = '1;
    logic [NUM_COL-1:0] opsumAfull = '0;
    logic preheatState, normalState, busy, done;

    int assertCount = 0;
    int failCount = 0;
    int jobCyc = 1000;
    exp_t expQ[$];
    logic [31:0] eIf [0:MAX_CYC-1];
    logic [31:0] eIp [0:MAX_CYC-1];
    logic [31:0] eOp [0:MAX_CYC-1];
    logic        eDone [0:MAX_CYC-1];

    always #5 clk = ~clk;

    token_scheduler_fsm_if #(.NUM_COL(NUM_COL)) fifoBus ();
    assign fifoBus.ifmap_fifo_empty_i = ifmapEmpty;
    assign fifoBus.ipsum_fifo_empty_i = ipsumEmpty;
    assign fifoBus.opsum_fifo_afull_i = opsumAfull;

    token_scheduler_fsm #(.NUM_COL(NUM_COL), .PREHEAT_DEPTH(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start_i             (start_i),
        .layer_type_i        (layerType),
        .cfg_num_tiles_i     (numTiles),
        .cfg_col_en_i        (colEn),
        .cfg_first_pass_i    (firstPass),
        .fifo_if             (fifoBus),
        .preheat_state_o     (preheatState),
        .normal_loop_state_o (normalState),
        .busy_o              (busy),
        .done_o              (done)
    );

    // Cycle 0 is the cycle start_i is high; the first PREHEAT cycle is 1.
    always @(posedge clk) begin
        if (start_i) jobCyc <= 1;
        else         jobCyc <= jobCyc + 1;
    end

    // Monitor: every cycle with any strobe or done_o must match the queue head.
    always @(negedge clk) begin
        if ((fifoBus.ifmap_fifo_pop_matrix_o | fifoBus.ipsum_fifo_pop_matrix_o |
             fifoBus.opsum_fifo_push_matrix_o) != '0 || done) begin
            exp_t e;
            assertCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpected_event cyc=%0d if=%h ip=%h op=%h done=%b",
                         jobCyc, fifoBus.ifmap_fifo_pop_matrix_o, fifoBus.ipsum_fifo_pop_matrix_o,
                         fifoBus.opsum_fifo_push_matrix_o, done);
            end else begin
                e = expQ.pop_front();
                if (e.cyc != jobCyc || e.ifPop !== fifoBus.ifmap_fifo_pop_matrix_o ||
                    e.ipPop !== fifoBus.ipsum_fifo_pop_matrix_o ||
                    e.opPush !== fifoBus.opsum_fifo_push_matrix_o || e.done !== done) begin
                    failCount++;
                    $display("[TB] FAIL strobe_event got cyc=%0d if=%h ip=%h op=%h done=%b expected cyc=%0d if=%h ip=%h op=%h done=%b",
                             jobCyc, fifoBus.ifmap_fifo_pop_matrix_o, fifoBus.ipsum_fifo_pop_matrix_o,
                             fifoBus.opsum_fifo_push_matrix_o, done, e.cyc, e.ifPop, e.ipPop, e.opPush, e.done);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, jobCyc);
        end
    endtask

    function automatic logic [127:0] allOutputs();
        return {preheatState, normalState, busy, done, fifoBus.ifmap_fifo_pop_matrix_o,
                fifoBus.ipsum_fifo_pop_matrix_o, fifoBus.opsum_fifo_push_matrix_o};
    endfunction

    task automatic clearExp();
        for (int c = 0; c < MAX_CYC; c++) begin
            eIf[c] = '0; eIp[c] = '0; eOp[c] = '0; eDone[c] = 1'b0;
        end
    endtask

    task automatic addPre(input int from, input int to, input logic [31:0] mask);
        for (int c = from; c <= to; c++) eIf[c] |= mask;
    endtask

    task automatic addBeat(input int c, input logic [31:0] mask, input logic [31:0] ipMask);
        eIf[c] |= mask;
        eIp[c] |= ipMask;
        eOp[c + 1] |= mask;
    endtask

    task automatic commitExp();
        for (int c = 0; c < MAX_CYC; c++) begin
            if ((eIf[c] | eIp[c] | eOp[c]) != '0 || eDone[c]) begin
                expQ.push_back('{cyc: c, ifPop: eIf[c], ipPop: eIp[c], opPush: eOp[c], done: eDone[c]});
            end
        end
    endtask

    // Runs one job; flag stalls are windows of job cycles on a single lane.
    task automatic applyStimulus(input logic [31:0] mask, input logic [15:0] tiles, input logic [1:0] lt,
                                 input logic fp, input logic ipsAllEmpty,
                                 input int ifLane, input int ifFrom, input int ifTo,
                                 input int afLane, input int afFrom, input int afTo,
                                 input int preEnd, input int normEnd, input int doneCyc, input int abortAt);
        bit finished = 0;
        @(posedge clk); #1;
        colEn = mask; numTiles = tiles; layerType = lt; firstPass = fp;
        ifmapEmpty = '0; ipsumEmpty = {NUM_COL{ipsAllEmpty}}; opsumAfull = '0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < 200 && !finished; k++) begin
            ifmapEmpty = '0;
            ipsumEmpty = {NUM_COL{ipsAllEmpty}};
            opsumAfull = '0;
            if (jobCyc >= ifFrom && jobCyc <= ifTo) ifmapEmpty[ifLane] = 1'b1;
            if (jobCyc >= afFrom && jobCyc <= afTo) opsumAfull[afLane] = 1'b1;
            if (abortAt >= 0 && jobCyc == abortAt) begin
                #1 rst_n = 1'b0;
                #1 checkOutput("abort_outputs_zero", allOutputs(), '0);
                finished = 1;
            end else begin
                @(negedge clk);
                checkOutput("phase_busy", {125'd0, preheatState, normalState, busy},
                            {125'd0, (jobCyc >= 1 && jobCyc <= preEnd),
                             (jobCyc > preEnd && jobCyc <= normEnd),
                             (jobCyc >= 1 && jobCyc <= doneCyc)});
                if (done) begin
                    checkOutput("done_cycle", 128'(jobCyc), 128'(doneCyc));
                    finished = 1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        if (!finished) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL job_timeout: got no done_o expected done at cycle %0d", doneCyc);
        end
        if (abortAt < 0) begin
            repeat (2) @(negedge clk);
            checkOutput("idle_after_done", allOutputs(), '0);
        end
        checkOutput("queue_drained", 128'(expQ.size()), 128'd0);
        expQ.delete();
    endtask

    initial begin
        $display("[TB] token_scheduler_fsm scoreboard bench");
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", allOutputs(), '0);
        rst_n = 1'b1;

        // Full mask, 4 tiles: done_o 39 cycles after the start cycle.
        clearExp();
        addPre(1, 32, 32'hFFFF_FFFF);
        for (int c = 34; c <= 37; c++) addBeat(c, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        eDone[39] = 1'b1;
        commitExp();
        applyStimulus(32'hFFFF_FFFF, 16'd4, LT_POINTWISE, 1'b0, 1'b0,
                      0, 1, 0, 0, 1, 0, 33, 37, 39, -1);

        // Four lanes, lane 2 ifmap empty for 5 cycles stretches preheat.
        clearExp();
        addPre(1, 5, 32'h0000_000B);
        addPre(6, 32, 32'h0000_000F);
        addPre(33, 37, 32'h0000_0004);
        addBeat(39, 32'h0000_000F, 32'h0);
        addBeat(40, 32'h0000_000F, 32'h0);
        eDone[42] = 1'b1;
        commitExp();
        applyStimulus(32'h0000_000F, 16'd2, LT_STANDARD, 1'b1, 1'b0,
                      2, 1, 5, 0, 1, 0, 38, 40, 42, -1);

        // Lane 0 opsum afull for 3 cycles stalls every lane.
        clearExp();
        addPre(1, 32, 32'h0000_0003);
        addBeat(34, 32'h3, 32'h3);
        addBeat(38, 32'h3, 32'h3);
        addBeat(39, 32'h3, 32'h3);
        addBeat(40, 32'h3, 32'h3);
        eDone[42] = 1'b1;
        commitExp();
        applyStimulus(32'h0000_0003, 16'd4, LT_STANDARD, 1'b0, 1'b0,
                      0, 1, 0, 0, 35, 37, 33, 40, 42, -1);

        // Zero tiles: preheat, drain, done with no ipsum/opsum activity.
        clearExp();
        addPre(1, 32, 32'h0000_0001);
        eDone[35] = 1'b1;
        commitExp();
        applyStimulus(32'h0000_0001, 16'd0, LT_LINEAR, 1'b0, 1'b0,
                      0, 1, 0, 0, 1, 0, 33, 33, 35, -1);

        // Empty mask and zero tiles: one preheat cycle.
        clearExp();
        eDone[3] = 1'b1;
        commitExp();
        applyStimulus(32'h0000_0000, 16'd0, LT_POINTWISE, 1'b0, 1'b0,
                      0, 1, 0, 0, 1, 0, 1, 1, 3, -1);

        // Depthwise with every ipsum FIFO empty still beats.
        clearExp();
        addPre(1, 32, 32'h0000_0005);
        for (int c = 34; c <= 36; c++) addBeat(c, 32'h5, 32'h0);
        eDone[38] = 1'b1;
        commitExp();
        applyStimulus(32'h0000_0005, 16'd3, LT_DEPTHWISE, 1'b0, 1'b1,
                      0, 1, 0, 0, 1, 0, 33, 36, 38, -1);

        // Reset in the middle of the normal loop, then a clean job.
        clearExp();
        addPre(1, 32, 32'h0000_00FF);
        eIf[34] = 32'hFF; eIp[34] = 32'hFF;
        eIf[35] = 32'hFF; eIp[35] = 32'hFF; eOp[35] = 32'hFF;
        commitExp();
        applyStimulus(32'h0000_00FF, 16'd10, LT_STANDARD, 1'b0, 1'b0,
                      0, 1, 0, 0, 1, 0, 33, 99, 99, 36);
        repeat (2) @(negedge clk);
        checkOutput("held_reset_outputs", allOutputs(), '0);
        rst_n = 1'b1;

        clearExp();
        addPre(1, 32, 32'h0000_0001);
        addBeat(34, 32'h1, 32'h1);
        eDone[36] = 1'b1;
        commitExp();
        applyStimulus(32'h0000_0001, 16'd1, LT_POINTWISE, 1'b0, 1'b0,
                      0, 1, 0, 0, 1, 0, 33, 34, 36, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
